// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at issue and held in pending registers until the latency counter expires.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic [31:0]  r_hi, r_lo, r_phi, r_plo;
    logic         r_commit_ok;
    logic         w_accept, w_is_md, w_is_div, w_commit, w_div_ovf;
    logic signed [63:0] w_a_s, w_b_s, w_prod_s;
    logic [63:0]  w_prod_u;
    logic [31:0]  w_div_s, w_div_u, w_quot_u, w_rem_u;
    logic signed [31:0] w_quot_raw, w_rem_raw;
    logic [31:0]  w_quot_s, w_rem_s;
    logic [63:0]  w_result;

    assign w_is_md  = ~op[2];
    assign w_is_div = op[1];
    assign w_accept = start & (r_state == S_IDLE);

    assign w_a_s    = {{32{a[31]}}, a};
    assign w_b_s    = {{32{b[31]}}, b};
    assign w_prod_s = w_a_s * w_b_s;
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Divisors are forced to 1 for the zero and INT_MIN/-1 cases so the divider never
    // sees an undefined operation; those results are substituted or discarded below.
    assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_div_s    = ((b == '0) || w_div_ovf) ? 32'd1 : b;
    assign w_div_u    = (b == '0) ? 32'd1 : b;
    assign w_quot_raw = $signed(a) / $signed(w_div_s);
    assign w_rem_raw  = $signed(a) % $signed(w_div_s);
    assign w_quot_s   = w_div_ovf ? 32'h8000_0000 : w_quot_raw;
    assign w_rem_s    = w_div_ovf ? '0 : w_rem_raw;
    assign w_quot_u   = a / w_div_u;
    assign w_rem_u    = a % w_div_u;

    always_comb begin
        w_result = '0;
        case (op[1:0])
            2'd0: w_result = w_prod_s;
            2'd1: w_result = w_prod_u;
            2'd2: w_result = {w_rem_s, w_quot_s};
            2'd3: w_result = {w_rem_u, w_quot_u};
            default: w_result = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_md) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_phi       <= '0;
            r_plo       <= '0;
            r_commit_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept && w_is_md) begin
                r_phi       <= w_result[63:32];
                r_plo       <= w_result[31:0];
                r_commit_ok <= !(w_is_div && (b == '0));
            end
            if (w_commit && r_commit_ok) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end else if (w_accept && (op == 3'd4)) begin
                r_hi <= a;
            end else if (w_accept && (op == 3'd5)) begin
                r_lo <= a;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected commits, monitor checks on busy fall.
module tb_mult_div_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        rst_edge = 1'b1;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference built from magnitudes and sign rules rather than native signed division.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] cur);
        int               ix, iy;
        longint           sx, sy, mq, mr, q, r;
        longint unsigned  ux, uy;
        ix = x; iy = y; sx = ix; sy = iy; ux = x; uy = y;
        case (o)
            3'd0: begin q = sx * sy; return q; end
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 0) return cur;
                mq = (sx < 0 ? -sx : sx) / (sy < 0 ? -sy : sy);
                mr = (sx < 0 ? -sx : sx) % (sy < 0 ? -sy : sy);
                q  = ((sx < 0) != (sy < 0)) ? -mq : mq;
                r  = (sx < 0) ? -mr : mr;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 0) return cur;
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return cur;
        endcase
    endfunction

    always @(posedge clk) rst_edge = reset;

    // Monitor: hi/lo must hold while busy; on busy fall compare against queue head.
    logic [31:0] last_hi = '0, last_lo = '0;
    int          run_len = 0;
    logic        prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst_edge) begin
            run_len = 0; prev_busy = 1'b0; last_hi = hi; last_lo = lo;
        end else if (busy) begin
            run_len++;
            chk("hold_hi", hi, last_hi);
            chk("hold_lo", lo, last_lo);
            prev_busy = 1'b1;
        end else begin
            if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_commit actual=busy_fall required=none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("commit_hi", hi, e.hi);
                    chk("commit_lo", lo, e.lo);
                    chk("busy_len", 32'(run_len), 32'(e.len));
                end
            end
            run_len = 0; prev_busy = 1'b0; last_hi = hi; last_lo = lo;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        exp_t e;
        logic [31:0] h0, l0;
        h0 = m_hi; l0 = m_lo;
        start = 1'b1; op = o; a = x; b = y;
        if (o < 3'd4) begin
            r = ref_result(o, x, y, {m_hi, m_lo});
            m_hi = r[63:32]; m_lo = r[31:0];
            e.hi = m_hi; e.lo = m_lo; e.len = (o < 3'd2) ? int'(MC) : int'(DC);
            exp_q.push_back(e);
        end else if (o == 3'd4) m_hi = x;
        else if (o == 3'd5) m_lo = x;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        if (o < 3'd4) wait_idle();
        else begin
            chk("mt_busy", {31'd0, busy}, 32'd0);
            chk("mt_hi", hi, m_hi);
            chk("mt_lo", lo, m_lo);
            if (o > 3'd5) begin
                chk("nop_hi", hi, h0);
                chk("nop_lo", lo, l0);
            end
        end
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'd7, 32'd2);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd4, 32'h11, 32'd0);
        do_op(3'd5, 32'h22, 32'd0);
        do_op(3'd2, 32'd1234, 32'd0);
        do_op(3'd3, 32'd99, 32'd0);

        // start during RUN must be ignored
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
        m_hi = 32'd0; m_lo = 32'd25;
        e.hi = m_hi; e.lo = m_lo; e.len = int'(MC);
        exp_q.push_back(e);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 3'd5; a = 32'hDEAD;
        @(negedge clk); start = 1'b0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            logic [2:0]  o;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: begin y = 32'hFFFF_FFFF; x = 32'h8000_0000; end
                3: y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            do_op(o, x, y);
        end

        // reset in busy cycle 4 aborts a DIV
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; exp_q.delete(); m_hi = '0; m_lo = '0;
        @(negedge clk); reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes the MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions that the decoder classifies as multiply/divide class. It owns the HI/LO registers, models a fixed multi-cycle latency, and exports `busy` to the hazard unit. The hazard unit stalls any later multiply/divide-class instruction in D while `start` or `busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; range 1..15.

- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: qualifies `op` for one cycle; driven by E-stage decode.
- `op` input 3: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO; 6 and 7 are no-ops.
- `a` input 32: rs operand, after forwarding.
- `b` input 32: rt operand, after forwarding.
- `busy` output 1: an operation is in flight.
- `hi` output 32: architectural HI register, read by MFHI.
- `lo` output 32: architectural LO register, read by MFLO.

## Operation
- **Reset.** While `reset` is high at an edge: `hi`=0, `lo`=0, `busy`=0, counter=0, pending result cleared. This takes priority over everything. Reset during an operation aborts it and the result is never committed.
- **States.**
  - IDLE: counter=0, `busy`=0.
  - RUN: counter>0, `busy`=1.
- **IDLE + `start` with op 0..3.**
  - Latch the operation and compute the 64-bit result into pending registers `phi`/`plo`.
  - Load counter with `MULT_CYCLES` (op 0/1) or `DIV_CYCLES` (op 2/3); go to RUN.
- **IDLE + `start` with op 4/5.** `hi` (op 4) or `lo` (op 5) := `a` at that edge. No busy cycle; stay in IDLE.
- **RUN, each edge.**
  - Counter decrements.
  - On the edge where it reaches 0: `hi`:=`phi`, `lo`:=`plo` (unless the op was a divide by zero), `busy`:=0, return to IDLE.
- **`start` while in RUN.** Ignored entirely; the in-flight operation is unaffected. The hazard unit guarantees this never happens in legal operation.
- **Arithmetic.**
  - MULT: {hi,lo} = signed(a)×signed(b), full 64 bits.
  - MULTU: {hi,lo} = unsigned(a)×unsigned(b), full 64 bits.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend `a`.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (`b`=0, DIV or DIVU): full latency runs, then `hi`/`lo` keep their prior values.
- `hi`/`lo` never change while in RUN except on the final commit edge.

## Timing
- `start` is sampled at edge E0; operands are captured at E0 only. Changes to `a`/`b` after E0 have no effect.
- MULT/MULTU:
  - `busy`=1 in the cycles following E0 through E5 (exactly `MULT_CYCLES` cycles).
  - `hi`/`lo` take the new value after E5, in the same cycle `busy` falls.
- DIV/DIVU: same pattern with `DIV_CYCLES` (commit after E10 by default).
- MTHI/MTLO: visible the cycle after E0; `busy` stays 0.
- A new `start` is accepted in the first cycle with `busy`=0, i.e. back-to-back with the commit edge.
- `hi`, `lo` and `busy` are registered outputs with no combinational path from inputs.

## Test plan
- **Reset.** Assert `reset` 2 cycles → `hi`=0, `lo`=0, `busy`=0.
- **MULT.** `start`, op=0, a=0xFFFFFFFE (−2), b=3 → `busy` high for exactly 5 cycles. On the cycle `busy` falls: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- **DIV.** op=2, a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1.
- **Divide by zero.** MTHI a=0x11, MTLO a=0x22, then DIV with b=0 → `busy` high 10 cycles; `hi`=0x11 and `lo`=0x22 unchanged.
- **`start` during RUN.** Issue MULTU 5×5, then assert `start` (op=5, a=0xDEAD) in busy cycle 2 → ignored; `lo`=25 at commit and `busy` length is still 5 cycles.
- **Reset mid-operation.** Start DIV 100/7, assert `reset` in busy cycle 4 → next cycle `busy`=0, `hi`=`lo`=0, and no later commit occurs.
